// File: rtl/ram_arbiter_if.sv
// Bundle of both core-side master channels and the shared RAM request/response channel.
// The arbiter binds to the slave modport; the surrounding masters and RAM use the master modport.
interface ram_arbiter_if;
  logic [31:0] m0_addr_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m0_data_i;
  logic [31:0] m1_data_i;
  logic [3:0]  m0_sel_i;
  logic [3:0]  m1_sel_i;
  logic        m0_we_i;
  logic        m1_we_i;
  logic        m0_req_valid_i;
  logic        m1_req_valid_i;
  logic        m0_req_ready_o;
  logic        m1_req_ready_o;
  logic        m0_rsp_valid_o;
  logic        m1_rsp_valid_o;
  logic        m0_rsp_ready_i;
  logic        m1_rsp_ready_i;
  logic [31:0] m0_data_o;
  logic [31:0] m1_data_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_data_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic        s_req_valid_o;
  logic        s_req_ready_i;
  logic        s_rsp_valid_i;
  logic        s_rsp_ready_o;
  logic [31:0] s_data_i;

  modport slave (
    input  m0_addr_i, m1_addr_i, m0_data_i, m1_data_i, m0_sel_i, m1_sel_i,
    input  m0_we_i, m1_we_i, m0_req_valid_i, m1_req_valid_i,
    input  m0_rsp_ready_i, m1_rsp_ready_i,
    output m0_req_ready_o, m1_req_ready_o, m0_rsp_valid_o, m1_rsp_valid_o,
    output m0_data_o, m1_data_o,
    output s_addr_o, s_data_o, s_sel_o, s_we_o, s_req_valid_o, s_rsp_ready_o,
    input  s_req_ready_i, s_rsp_valid_i, s_data_i
  );

  modport master (
    output m0_addr_i, m1_addr_i, m0_data_i, m1_data_i, m0_sel_i, m1_sel_i,
    output m0_we_i, m1_we_i, m0_req_valid_i, m1_req_valid_i,
    output m0_rsp_ready_i, m1_rsp_ready_i,
    input  m0_req_ready_o, m1_req_ready_o, m0_rsp_valid_o, m1_rsp_valid_o,
    input  m0_data_o, m1_data_o,
    input  s_addr_o, s_data_o, s_sel_o, s_we_o, s_req_valid_o, s_rsp_ready_o,
    output s_req_ready_i, s_rsp_valid_i, s_data_i
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for one single-port RAM, one outstanding transaction, RR or fixed priority.
// Grant is combinational in IDLE (0-cycle); backpressure from RAM and owner response-ready is passed straight through.
module ram_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RSP  = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

  logic   grant;
  logic   sel_m;
  logic   sel_vld;
  logic   req_vld;
  logic   rsp_phase;
  logic   owner_rsp_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    grant     = 1'b0;
    sel_m     = owner_q;
    sel_vld   = 1'b0;
    req_vld   = 1'b0;
    rsp_phase = 1'b0;
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;

    // Tie goes to m0 in fixed-priority mode, otherwise to whoever was not served last.
    if (bus.m0_req_valid_i && bus.m1_req_valid_i) begin
      grant = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      grant = bus.m1_req_valid_i;
    end

    if (state_q == IDLE) begin
      sel_m = grant;
    end
    sel_vld = sel_m ? bus.m1_req_valid_i : bus.m0_req_valid_i;
    owner_rsp_rdy = owner_q ? bus.m1_rsp_ready_i : bus.m0_rsp_ready_i;

    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          req_vld = 1'b1;
          owner_d = grant;
          if (bus.s_req_ready_i) begin
            last_d  = grant;
            state_d = RSP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Owner keeps the RAM until accepted; a withdrawn request just frees the arbiter.
        if (sel_vld) begin
          req_vld = 1'b1;
          if (bus.s_req_ready_i) begin
            last_d  = owner_q;
            state_d = RSP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RSP: begin
        rsp_phase = 1'b1;
        if (bus.s_rsp_valid_i && owner_rsp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_addr_o = sel_m ? bus.m1_addr_i : bus.m0_addr_i;
  assign bus.s_data_o = sel_m ? bus.m1_data_i : bus.m0_data_i;
  assign bus.s_sel_o  = sel_m ? bus.m1_sel_i  : bus.m0_sel_i;
  assign bus.s_we_o   = sel_m ? bus.m1_we_i   : bus.m0_we_i;

  // Handshake outputs are forced low while reset is held.
  assign bus.s_req_valid_o  = rst_n & req_vld;
  assign bus.m0_req_ready_o = rst_n & req_vld & ~sel_m & bus.s_req_ready_i;
  assign bus.m1_req_ready_o = rst_n & req_vld &  sel_m & bus.s_req_ready_i;
  assign bus.s_rsp_ready_o  = rst_n & rsp_phase & owner_rsp_rdy;
  assign bus.m0_rsp_valid_o = rst_n & rsp_phase & ~owner_q & bus.s_rsp_valid_i;
  assign bus.m1_rsp_valid_o = rst_n & rsp_phase &  owner_q & bus.s_rsp_valid_i;

  assign bus.m0_data_o = bus.s_data_i;
  assign bus.m1_data_o = bus.s_data_i;

  a_rsp_only_in_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    bus.s_rsp_valid_i |-> (state_q == RSP));

endmodule
